tl_channel_buffer: RTL

TL_CHANNEL_BUFFER -- requirements
Module: tl_channel_buffer

---
 rtl/tl_channel_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tl_channel_buffer.sv
// TileLink A/D channel buffer: two independent FIFO queues with
// configurable depth (0 = wire-through) and optional flow bypass.

module tl_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int FLOW  = 0,
    parameter int CW    = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] count
);
    if (DEPTH == 0) begin : g_pass
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign out_data  = in_data;
        assign count     = '0;
    end else begin : g_fifo
        localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

        logic [W-1:0]  mem [DEPTH];
        logic [PW-1:0] rptr;
        logic [PW-1:0] wptr;
        logic [CW-1:0] cnt;
        logic          empty;
        logic          bypass;
        logic          enq;
        logic          deq;

        function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
            return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
        endfunction

        assign empty     = (cnt == '0);
        // Ready looks only at the registered count, never at out_ready.
        assign in_ready  = (cnt < CW'(DEPTH));
        assign bypass    = (FLOW != 0) && empty && in_valid;
        assign out_valid = !empty || bypass;
        assign out_data  = empty ? in_data : mem[rptr];
        assign enq       = in_valid && in_ready && !(bypass && out_ready);
        assign deq       = !empty && out_ready;
        assign count     = cnt;

        always_ff @(posedge clock) begin
            if (reset) begin
                rptr <= '0;
                wptr <= '0;
                cnt  <= '0;
            end else begin
                if (enq) wptr <= nxt(wptr);
                if (deq) rptr <= nxt(rptr);
                if (enq && !deq) begin
                    cnt <= cnt + 1'b1;
                end else if (!enq && deq) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (enq) mem[wptr] <= in_data;
        end
    end
endmodule

module tl_channel_buffer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SOURCE_W = 4,
    parameter int SIZE_W   = 3,
    parameter int A_DEPTH  = 2,
    parameter int D_DEPTH  = 2,
    parameter int A_FLOW   = 0,
    parameter int D_FLOW   = 0,
    localparam int MW  = DATA_W / 8,
    localparam int ACW = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
    localparam int DCW = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_in_valid,
    output logic                a_in_ready,
    input  logic [2:0]          a_in_opcode,
    input  logic [2:0]          a_in_param,
    input  logic [SIZE_W-1:0]   a_in_size,
    input  logic [SOURCE_W-1:0] a_in_source,
    input  logic [ADDR_W-1:0]   a_in_address,
    input  logic [MW-1:0]       a_in_mask,
    input  logic [DATA_W-1:0]   a_in_data,
    input  logic                a_in_corrupt,
    output logic                a_out_valid,
    input  logic                a_out_ready,
    output logic [2:0]          a_out_opcode,
    output logic [2:0]          a_out_param,
    output logic [SIZE_W-1:0]   a_out_size,
    output logic [SOURCE_W-1:0] a_out_source,
    output logic [ADDR_W-1:0]   a_out_address,
    output logic [MW-1:0]       a_out_mask,
    output logic [DATA_W-1:0]   a_out_data,
    output logic                a_out_corrupt,
    input  logic                d_in_valid,
    output logic                d_in_ready,
    input  logic [2:0]          d_in_opcode,
    input  logic [1:0]          d_in_param,
    input  logic [SIZE_W-1:0]   d_in_size,
    input  logic [SOURCE_W-1:0] d_in_source,
    input  logic                d_in_denied,
    input  logic [DATA_W-1:0]   d_in_data,
    input  logic                d_in_corrupt,
    output logic                d_out_valid,
    input  logic                d_out_ready,
    output logic [2:0]          d_out_opcode,
    output logic [1:0]          d_out_param,
    output logic [SIZE_W-1:0]   d_out_size,
    output logic [SOURCE_W-1:0] d_out_source,
    output logic                d_out_denied,
    output logic [DATA_W-1:0]   d_out_data,
    output logic                d_out_corrupt,
    output logic [ACW-1:0]      a_count,
    output logic [DCW-1:0]      d_count
);
    localparam int AW = 7 + SIZE_W + SOURCE_W + ADDR_W + MW + DATA_W;
    localparam int DW = 7 + SIZE_W + SOURCE_W + DATA_W;

    logic [AW-1:0] a_in_q;
    logic [AW-1:0] a_out_q;
    logic [DW-1:0] d_in_q;
    logic [DW-1:0] d_out_q;

    assign a_in_q = {a_in_opcode, a_in_param, a_in_size, a_in_source,
                     a_in_address, a_in_mask, a_in_data, a_in_corrupt};
    assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
            a_out_address, a_out_mask, a_out_data, a_out_corrupt} = a_out_q;

    assign d_in_q = {d_in_opcode, d_in_param, d_in_size, d_in_source,
                     d_in_denied, d_in_data, d_in_corrupt};
    assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
            d_out_denied, d_out_data, d_out_corrupt} = d_out_q;

    tl_queue #(.W(AW), .DEPTH(A_DEPTH), .FLOW(A_FLOW), .CW(ACW)) u_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_q),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_q), .count(a_count)
    );

    tl_queue #(.W(DW), .DEPTH(D_DEPTH), .FLOW(D_FLOW), .CW(DCW)) u_d (
        .clock(clock), .reset(reset),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_q),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_q), .count(d_count)
    );
endmodule
